// File: rtl/ntt_frame_serializer.sv
// ntt_frame_serializer
// Takes one parallel frame of INPUT_PER_CYCLE coefficient words from the NTT core
// and emits it one word per cycle, word 0 first. Two frame banks are used in
// ping-pong fashion so that a new frame can be loaded while the previous one is
// still streaming. This lets frames leave back-to-back with no idle cycles between them.
module ntt_frame_serializer #(
    parameter int DATA_WIDTH_PER_INPUT = 32,
    parameter int INPUT_PER_CYCLE      = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] in_data [INPUT_PER_CYCLE-1:0],
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH_PER_INPUT-1:0] out_data,
    output logic                            out_first,
    output logic                            out_last,
    output logic [1:0]                      occupancy
);

    localparam int               IDX_W    = $clog2(INPUT_PER_CYCLE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_PER_CYCLE - 1);

    // Control state: bank pointers, number of frames held and read index
    logic             r_wr_sel;
    logic             r_rd_sel;
    logic [1:0]       r_count;
    logic [IDX_W-1:0] r_idx;

    // Handshake qualifiers
    logic w_accept;
    logic w_pop;
    logic w_pop_last;

    // Word at the current read index of each bank
    logic [DATA_WIDTH_PER_INPUT-1:0] w_bank_word [2];

    // Readiness comes from the registered count only, so in_valid never feeds in_ready
    assign in_ready   = !rst && (r_count != 2'd2);
    assign out_valid  = (r_count != 2'd0);
    assign w_accept   = in_valid && in_ready;
    assign w_pop      = out_valid && out_ready;
    assign w_pop_last = w_pop && (r_idx == LAST_IDX);

    // Two frame banks; the bank selected by r_wr_sel captures the whole frame on accept
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic [DATA_WIDTH_PER_INPUT-1:0] r_words [INPUT_PER_CYCLE-1:0];

        // Frame capture into this bank. Contents are not reset because count gates their use
        always_ff @(posedge clk) begin
            if (w_accept && (r_wr_sel == 1'(gi))) begin
                for (int i = 0; i < INPUT_PER_CYCLE; i++) begin
                    r_words[i] <= in_data[i];
                end
            end
        end

        assign w_bank_word[gi] = r_words[r_idx];
    end

    // Pointer, occupancy and index update. A frame is released only when its last word transfers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_sel <= 1'b0;
            r_rd_sel <= 1'b0;
            r_count  <= 2'd0;
            r_idx    <= '0;
        end else begin
            if (w_accept) begin
                r_wr_sel <= ~r_wr_sel;
            end
            if (w_pop) begin
                r_idx <= w_pop_last ? '0 : r_idx + IDX_W'(1);
            end
            if (w_pop_last) begin
                r_rd_sel <= ~r_rd_sel;
            end
            case ({w_accept, w_pop_last})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Serial output path. Data is forced to zero whenever no word is valid
    always_comb begin
        out_data  = '0;
        out_first = 1'b0;
        out_last  = 1'b0;
        if (out_valid) begin
            out_data  = w_bank_word[r_rd_sel];
            out_first = (r_idx == '0);
            out_last  = (r_idx == LAST_IDX);
        end
    end

    assign occupancy = r_count;

endmodule
